// File: rtl/currctrl_reset_sequencer.sv
// Staged reset sequencer for the current-control datapath: stretches soft-reset
// and fault requests, then releases the reset domains one by one in ascending order.
module currctrl_reset_sequencer #(
    parameter int NUM_STAGES        = 3,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int STAGE_GAP_CYCLES  = 8,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sw_reset_req,
    input  logic                  fault_in,
    input  logic                  fault_clr,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  busy,
    output logic                  fault_latched,
    output logic [7:0]            rst_count
);

    localparam int CNT_MAX = (MIN_ASSERT_CYCLES > STAGE_GAP_CYCLES) ? MIN_ASSERT_CYCLES
                                                                    : STAGE_GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_flt_sync;
    logic                   w_req_s;
    logic                   w_flt_s;
    logic                   w_hold;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_STAGES-1:0]  r_stage_rst_n;
    logic                   r_busy;
    logic                   r_fault_latched;
    logic [7:0]             r_rst_count;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [NUM_STAGES-1:0]  w_stage_nxt;
    logic                   w_busy_nxt;
    logic                   w_reassert;

    // NOTE: reset_n is sampled only on the clock edge; it is deliberately
    // absent from the sensitivity list, so every flop here resets synchronously.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_req_sync <= '0;
            r_flt_sync <= '0;
        end else begin
            // NOTE: non-blocking assignment lets each flop take its neighbour's
            // pre-edge value, which is what makes this a shift chain.
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], sw_reset_req};
            r_flt_sync <= {r_flt_sync[SYNC_STAGES-2:0], fault_in};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_flt_s = r_flt_sync[SYNC_STAGES-1];
    assign w_hold  = w_req_s | r_fault_latched | w_flt_s;

    // A live fault always wins over a CPU clear on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fault_latched <= 1'b0;
        end else if (w_flt_s) begin
            r_fault_latched <= 1'b1;
        end else if (fault_clr) begin
            r_fault_latched <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_ASSERT;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage_rst_n <= '0;
            r_busy        <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_stage_rst_n <= w_stage_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rst_count <= '0;
        end else if (w_reassert && (r_rst_count != 8'hFF)) begin
            r_rst_count <= r_rst_count + 8'd1;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_stage_nxt = r_stage_rst_n;
        w_busy_nxt  = r_busy;
        w_reassert  = 1'b0;

        case (r_state)
            ST_ASSERT: begin
                w_stage_nxt = '0;
                w_busy_nxt  = 1'b1;
                if (w_hold) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_W'(MIN_ASSERT_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = IDX_W'(1);
                    w_stage_nxt = NUM_STAGES'(1);
                    if (NUM_STAGES == 1) begin
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (w_hold) begin
                    w_state_nxt = ST_ASSERT;
                    w_stage_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_reassert  = 1'b1;
                end else if (r_cnt == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
                    // Shifting in a one keeps the released bits a contiguous low run.
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 1'b1;
                    w_stage_nxt = (r_stage_rst_n << 1) | NUM_STAGES'(1);
                    if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                w_stage_nxt = '1;
                w_busy_nxt  = 1'b0;
                if (w_hold) begin
                    w_state_nxt = ST_ASSERT;
                    w_stage_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_reassert  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_ASSERT;
                w_stage_nxt = '0;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign stage_rst_n   = r_stage_rst_n;
    assign busy          = r_busy;
    assign fault_latched = r_fault_latched;
    assign rst_count     = r_rst_count;

endmodule

// File: doc/currctrl_reset_sequencer.md
Name: currctrl_reset_sequencer

Overview:
Downstream consumer of the CurrCTRL soft-reset PIO bit. It turns the software reset request and an external fault into stretched, staged resets for the current-control datapath. Sub-domains are released in a fixed order, for example ADC front end, then control loop, then PWM/coil driver. It also exposes busy, latched-fault and reset-event status for CPU readback through a neighbouring PIO.

Parameters:
NUM_STAGES, 3, number of reset domains released in order; legal range 1..8
MIN_ASSERT_CYCLES, 16, minimum cycles all stages are held in reset after the last hold condition clears; must be >= 1
STAGE_GAP_CYCLES, 8, cycles between release of stage i-1 and stage i; must be >= 1
SYNC_STAGES, 2, flip-flops in each input synchroniser; must be >= 2

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
sw_reset_req  in  1  level-sensitive soft-reset request, active-high, driven by the SYS_Reset PIO out_port
fault_in  in  1  external fault, active-high, asynchronous (for example overcurrent)
fault_clr  in  1  single-cycle pulse from the CPU that clears the latched fault
stage_rst_n  out  NUM_STAGES  per-domain reset, active-low; bit 0 is released first
busy  out  1  high while any stage_rst_n bit is low
fault_latched  out  1  sticky fault flag
rst_count  out  8  saturating count of reset events initiated after power-up

Behaviour:
- Reset: one clock domain; reset is synchronous and active-low on reset_n, sampled on the rising edge of clk.
- While reset_n is low:
  - state = ASSERT, cnt = 0, stage index = 0
  - stage_rst_n = all 0, busy = 1, fault_latched = 0, rst_count = 0
  - all synchroniser flops = 0
- Input synchronisers: sw_reset_req and fault_in each pass through a SYNC_STAGES-deep chain, producing req_s and flt_s. fault_clr is already synchronous and is not synchronised.
- fault_latched:
  - Set on any edge where flt_s = 1.
  - Cleared on an edge where fault_clr = 1 and flt_s = 0.
  - If set and clear occur together, set wins.
- hold = req_s OR fault_latched OR flt_s.
- State ASSERT:
  - stage_rst_n = all 0, busy = 1.
  - If hold, cnt <= 0.
  - Else if cnt == MIN_ASSERT_CYCLES-1: go to RELEASE, stage_rst_n[0] <= 1, cnt <= 0, index <= 1. If NUM_STAGES == 1, go directly to RUN and busy <= 0 on the same edge.
  - Else cnt <= cnt+1.
- State RELEASE:
  - If hold: enter ASSERT, with stage_rst_n <= 0 and cnt <= 0 on the same edge.
  - Else if cnt == STAGE_GAP_CYCLES-1: stage_rst_n[index] <= 1, cnt <= 0, index <= index+1.
  - When the last stage is released, go to RUN and drop busy on that same edge.
  - Else cnt <= cnt+1.
- State RUN:
  - stage_rst_n = all 1, busy = 0.
  - If hold: enter ASSERT, with stage_rst_n <= 0 on the same edge.
- Release order is strictly ascending bit index. A higher bit is never released before a lower one, and all bits drop together.
- rst_count increments by 1 on every RELEASE->ASSERT or RUN->ASSERT transition and saturates at 255. Power-up reset does not count; neither does hold while already in ASSERT.
- Latency: a sw_reset_req rising edge held stable drives stage_rst_n low on the (SYNC_STAGES+1)th rising edge after it is first sampled.
- A request pulse shorter than one clock period may be missed; software holds the PIO bit for at least 2 cycles.
- All outputs are registered. No combinational path from any input to any output.

Test Plan:
- Power-up (defaults):
  - Stimulus: reset_n low 5 cycles, then high; sw_reset_req = 0, fault_in = 0.
  - Required response: stage_rst_n = 000 until the 16th edge with reset_n high; 001 at edge 16, 011 at edge 24, 111 at edge 32. busy falls at edge 32. rst_count = 0.
- Soft reset pulse:
  - Stimulus: in RUN, sw_reset_req high for 2 cycles.
  - Required response: stage_rst_n = 000 on the 3rd edge after the rise. The release sequence restarts 16 edges after req_s falls. rst_count = 1.
- Stretched request:
  - Stimulus: sw_reset_req held high for 40 cycles.
  - Required response: stage_rst_n stays 000 for all 40 cycles plus the synchroniser delay plus 16 cycles. rst_count increments only once.
- Fault latch:
  - Stimulus: 1-cycle fault_in in RUN.
  - Required response: stage_rst_n = 000 and fault_latched = 1, held indefinitely.
  - Stimulus: fault_clr while fault_in is still high.
  - Required response: ignored.
  - Stimulus: fault_clr and fault_in rise on the same cycle.
  - Required response: latch stays set.
  - Stimulus: fault_clr after fault_in is low.
  - Required response: fault_latched = 0, then the normal 16/8/8 release sequence.
- Abort mid-release:
  - Stimulus: request arriving when stage_rst_n = 001, 4 cycles into the gap.
  - Required response: stage_rst_n = 000 on the next edge after req_s = 1. The full sequence then restarts from cnt = 0. rst_count increments.
- Saturation and reset mid-operation:
  - Stimulus: 300 request pulses.
  - Required response: rst_count = 255.
  - Stimulus: reset_n low during RELEASE.
  - Required response: all outputs return to their reset values on that edge.
